// File: rtl/icache_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// icache_fetch_unit_if
// Purpose : bundles the processor fetch port and the line-wide instruction
//           memory port of the instruction cache.
// Signals : proc_read/proc_addr   fetch request (word address)
//           proc_rdata/proc_stall instruction word / not-served indication
//           mem_read/mem_addr     line refill request (line address)
//           mem_rdata/mem_ready   refill line / one-cycle data-valid pulse
// Modports: slave  - the cache (serves fetches, issues refills)
//           master - the environment (PC datapath + instruction memory)
// ---------------------------------------------------------------------------
interface icache_fetch_unit_if #(
  parameter int unsigned ADDR_W = 30
);
  localparam int unsigned LINE_W = 128;

  logic              proc_read;
  logic [ADDR_W-1:0] proc_addr;
  logic [31:0]       proc_rdata;
  logic              proc_stall;
  logic              mem_read;
  logic [ADDR_W-3:0] mem_addr;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  proc_read, proc_addr, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_addr
  );

  modport master (
    output proc_read, proc_addr, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_addr
  );
endinterface

// File: rtl/icache_fetch_unit.sv
// ---------------------------------------------------------------------------
// icache_fetch_unit
// Purpose : read-only direct-mapped instruction cache for the multicycle
//           MIPS fetch path. Hits answer combinationally; a miss stalls the
//           processor, refills one 4-word line, then releases the stall.
// Ports   : clk_i       clock, all state on posedge
//           rst_i       synchronous active-high reset (clears valid bits)
//           bus_if      icache_fetch_unit_if.slave (processor + memory side)
//           hit_cnt_o   [ICACHE_STATS_EN only] saturating hit counter
//           miss_cnt_o  [ICACHE_STATS_EN only] saturating miss counter
// Config  : define ICACHE_STATS_EN to add the hit/miss statistics counters.
// ---------------------------------------------------------------------------
module icache_fetch_unit #(
  parameter int unsigned NUM_BLOCKS = 8,
  parameter int unsigned ADDR_W     = 30
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  icache_fetch_unit_if.slave         bus_if
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]                hit_cnt_o,
  output logic [31:0]                miss_cnt_o
`endif
);

  localparam int unsigned LINE_W   = 128;
  localparam int unsigned IDX_W    = $clog2(NUM_BLOCKS);
  localparam int unsigned LADDR_W  = ADDR_W - 2;
  localparam int unsigned TAG_W    = LADDR_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    REFILL = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [LADDR_W-1:0]   miss_addr_q, miss_addr_d;
  logic [NUM_BLOCKS-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_BLOCKS];
  logic [LINE_W-1:0]    data_q [NUM_BLOCKS];

  logic [1:0]           offset_c;
  logic [IDX_W-1:0]     idx_c;
  logic [TAG_W-1:0]     tag_c;
  logic [IDX_W-1:0]     miss_idx_c;
  logic [TAG_W-1:0]     miss_tag_c;
  logic                 hit_c;
  logic                 refill_c;

  // Address split of the incoming request and of the latched miss line
  assign offset_c   = bus_if.proc_addr[1:0];
  assign idx_c      = bus_if.proc_addr[IDX_W+1:2];
  assign tag_c      = bus_if.proc_addr[ADDR_W-1:IDX_W+2];
  assign miss_idx_c = miss_addr_q[IDX_W-1:0];
  assign miss_tag_c = miss_addr_q[LADDR_W-1:IDX_W];

  // Lookups are only honoured in IDLE; valid is tested first so stale tags never matter
  assign hit_c = bus_if.proc_read && valid_q[idx_c] && (tag_q[idx_c] == tag_c)
                 && (state_q == IDLE);

  // mem_ready is only meaningful while a refill is outstanding
  assign refill_c = (state_q == FETCH) && bus_if.mem_ready;

  // Processor-facing outputs are combinational by design (same-cycle hit)
  assign bus_if.proc_stall = bus_if.proc_read && !hit_c;
  assign bus_if.proc_rdata = hit_c ? data_q[idx_c][{offset_c, 5'd0} +: 32] : 32'd0;

  // Memory-facing outputs decode straight from registers, so they stay stable during FETCH
  assign bus_if.mem_read = (state_q == FETCH);
  assign bus_if.mem_addr = miss_addr_q;

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    case (state_q)
      IDLE: begin
        if (bus_if.proc_read && !hit_c) begin
          miss_addr_d = bus_if.proc_addr[ADDR_W-1:2];
          state_d     = FETCH;
        end
      end
      FETCH: begin
        if (bus_if.mem_ready) begin
          state_d = REFILL;
        end
      end
      REFILL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, miss address and valid bits
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      if (refill_c) begin
        valid_q[miss_idx_c] <= 1'b1;
      end
    end
  end

  // Tag/data storage: no reset, written only by a completing refill
  always_ff @(posedge clk_i) begin
    if (!rst_i && refill_c) begin
      tag_q[miss_idx_c]  <= miss_tag_c;
      data_q[miss_idx_c] <= bus_if.mem_rdata;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Saturating statistics counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_c && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if ((state_q == IDLE) && (state_d == FETCH) && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
